// File: rtl/waveform_pkg.sv
//------------------------------------------------------------------------------
// Module      : waveform_pkg
// Description : Shared widths, default colours and saturating helpers for the
//               waveform plotter pixel stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package waveform_pkg;

  localparam int PIX_W = 11;
  localparam int RGB_W = 16;

  localparam logic [RGB_W-1:0] COLOR_SINE_DEF = 16'hF800;
  localparam logic [RGB_W-1:0] COLOR_TRI_DEF  = 16'h07E0;
  localparam logic [RGB_W-1:0] COLOR_SQR_DEF  = 16'h001F;
  localparam logic [RGB_W-1:0] COLOR_GRID_DEF = 16'h4208;
  localparam logic [RGB_W-1:0] COLOR_BG_DEF   = 16'h0000;

  // Extra top bit acts as borrow/carry; clamp instead of wrapping.
  function automatic logic [PIX_W-1:0] sat_sub(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W:0]   b);
    logic [PIX_W:0] d;
    d = {1'b0, a} - b;
    return d[PIX_W] ? '0 : d[PIX_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W:0]   b);
    logic [PIX_W:0] s;
    s = {1'b0, a} + b;
    return s[PIX_W] ? '1 : s[PIX_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/waveform_plotter_if.sv
//------------------------------------------------------------------------------
// Module      : waveform_plotter_if
// Description : Pixel position, trace heights and RGB565 output of the plotter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface waveform_plotter_if;
  import waveform_pkg::*;

  logic [PIX_W-1:0] pix_x;
  logic [PIX_W-1:0] pix_y;
  logic             pix_valid;
  logic [PIX_W-1:0] waveform_y_sine;
  logic [PIX_W-1:0] waveform_y_triangle;
  logic [PIX_W-1:0] waveform_y_square;
  logic             grid_en;
  logic [RGB_W-1:0] pix_data;
  logic             pix_data_valid;

  modport master (
    output pix_x, pix_y, pix_valid,
    output waveform_y_sine, waveform_y_triangle, waveform_y_square, grid_en,
    input  pix_data, pix_data_valid
  );

  modport slave (
    input  pix_x, pix_y, pix_valid,
    input  waveform_y_sine, waveform_y_triangle, waveform_y_square, grid_en,
    output pix_data, pix_data_valid
  );

endinterface

`default_nettype wire

// File: rtl/trace_hit.sv
//------------------------------------------------------------------------------
// Module      : trace_hit
// Description : Decides whether the aligned line lies on the vertical segment
//               joining the previous and current sample of one trace.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module trace_hit
  import waveform_pkg::*;
#(
  parameter int THICK = 1
) (
  input  logic             vga_clk,
  input  logic             sys_rstn,
  input  logic [PIX_W-1:0] cur_y,
  input  logic [PIX_W-1:0] pix_y_a,
  input  logic             line_start,
  input  logic             valid_a,
  output logic             hit
);

  localparam logic [PIX_W:0] c_thick = (PIX_W+1)'(THICK);

  logic [PIX_W-1:0] r_prev_y;
  logic [PIX_W-1:0] w_prev;
  logic [PIX_W-1:0] w_min;
  logic [PIX_W-1:0] w_max;
  logic [PIX_W-1:0] w_lo;
  logic [PIX_W-1:0] w_hi;

  // At line start the segment collapses to the current sample only.
  always_comb begin
    w_prev = line_start ? cur_y : r_prev_y;
    w_min  = (w_prev < cur_y) ? w_prev : cur_y;
    w_max  = (w_prev < cur_y) ? cur_y  : w_prev;
    w_lo   = sat_sub(w_min, c_thick);
    w_hi   = sat_add(w_max, c_thick);
    hit    = valid_a && (pix_y_a >= w_lo) && (pix_y_a <= w_hi);
  end

  always_ff @(posedge vga_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_prev_y <= '0;
    end else if (valid_a) begin
      r_prev_y <= cur_y;
    end
  end

endmodule

`default_nettype wire

// File: rtl/waveform_plotter.sv
//------------------------------------------------------------------------------
// Module      : waveform_plotter
// Description : Aligns pixel position with generator trace heights and renders
//               traces, grid and background as RGB565 with 2-cycle latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module waveform_plotter
  import waveform_pkg::*;
#(
  parameter int               THICK      = 1,
  parameter int               GRID_X     = 64,
  parameter int               GRID_Y     = 50,
  parameter logic [RGB_W-1:0] COLOR_SINE = COLOR_SINE_DEF,
  parameter logic [RGB_W-1:0] COLOR_TRI  = COLOR_TRI_DEF,
  parameter logic [RGB_W-1:0] COLOR_SQR  = COLOR_SQR_DEF,
  parameter logic [RGB_W-1:0] COLOR_GRID = COLOR_GRID_DEF,
  parameter logic [RGB_W-1:0] COLOR_BG   = COLOR_BG_DEF
) (
  input  logic               vga_clk,
  input  logic               sys_rstn,
  waveform_plotter_if.slave  bus
);

  localparam logic [PIX_W-1:0] c_gx_last = PIX_W'(GRID_X - 1);
  localparam logic [PIX_W-1:0] c_gy_last = PIX_W'(GRID_Y - 1);

  logic [PIX_W-1:0] r_pix_y_a;
  logic             r_valid_a;
  logic             r_data_valid;
  logic [RGB_W-1:0] r_pix_data;
  logic [PIX_W-1:0] r_gx;
  logic [PIX_W-1:0] r_gy;

  logic             w_line_start;
  logic             w_line_end;
  logic [PIX_W-1:0] w_gx;
  logic [PIX_W-1:0] w_gy;
  logic [PIX_W-1:0] w_cur_y [3];
  logic [2:0]       w_hit;
  logic [RGB_W-1:0] w_colour;

  // Stage A: the generator's y outputs arrive one cycle after pix_x.
  always_ff @(posedge vga_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_pix_y_a <= '0;
      r_valid_a <= 1'b0;
    end else begin
      r_pix_y_a <= bus.pix_y;
      r_valid_a <= bus.pix_valid;
    end
  end

  // r_data_valid is r_valid_a delayed once, which doubles as edge history.
  assign w_line_start = r_valid_a & ~r_data_valid;
  assign w_line_end   = ~r_valid_a & r_data_valid;

  assign w_cur_y[0] = bus.waveform_y_sine;
  assign w_cur_y[1] = bus.waveform_y_triangle;
  assign w_cur_y[2] = bus.waveform_y_square;

  for (genvar i = 0; i < 3; i++) begin : g_trace
    trace_hit #(.THICK(THICK)) u_trace_hit (
      .vga_clk    (vga_clk),
      .sys_rstn   (sys_rstn),
      .cur_y      (w_cur_y[i]),
      .pix_y_a    (r_pix_y_a),
      .line_start (w_line_start),
      .valid_a    (r_valid_a),
      .hit        (w_hit[i])
    );
  end

  assign w_gx = w_line_start ? '0 : r_gx;
  assign w_gy = (w_line_start && (r_pix_y_a == '0)) ? '0 : r_gy;

  always_ff @(posedge vga_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_gx <= '0;
      r_gy <= '0;
    end else begin
      if (r_valid_a) begin
        r_gx <= (w_gx == c_gx_last) ? '0 : w_gx + 1'b1;
      end
      if (w_line_end) begin
        r_gy <= (r_gy == c_gy_last) ? '0 : r_gy + 1'b1;
      end else if (w_line_start) begin
        r_gy <= w_gy;
      end
    end
  end

  always_comb begin
    w_colour = COLOR_BG;
    if (w_hit[0]) begin
      w_colour = COLOR_SINE;
    end else if (w_hit[1]) begin
      w_colour = COLOR_TRI;
    end else if (w_hit[2]) begin
      w_colour = COLOR_SQR;
    end else if (bus.grid_en && ((w_gx == '0) || (w_gy == '0))) begin
      w_colour = COLOR_GRID;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_data_valid <= 1'b0;
      r_pix_data   <= '0;
    end else begin
      r_data_valid <= r_valid_a;
      r_pix_data   <= r_valid_a ? w_colour : '0;
    end
  end

  assign bus.pix_data       = r_pix_data;
  assign bus.pix_data_valid = r_data_valid;

endmodule

`default_nettype wire

// File: tb/tb_waveform_plotter.sv
//------------------------------------------------------------------------------
// Module      : tb_waveform_plotter
// Description : Scoreboard bench for waveform_plotter against a per-pixel model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_waveform_plotter;
  import waveform_pkg::*;

  localparam int THICK  = 1;
  localparam int GRID_X = 64;
  localparam int GRID_Y = 50;

  logic vga_clk  = 1'b0;
  logic sys_rstn = 1'b0;

  always #5 vga_clk = ~vga_clk;

  waveform_plotter_if bus ();

  waveform_plotter #(
    .THICK  (THICK),
    .GRID_X (GRID_X),
    .GRID_Y (GRID_Y)
  ) dut (
    .vga_clk  (vga_clk),
    .sys_rstn (sys_rstn),
    .bus      (bus)
  );

  typedef struct {
    int          tag;
    logic        v;
    logic [15:0] d;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Monitor: each issued pixel appears two clocks after it is driven.
  always @(negedge vga_clk) begin
    exp_t e;
    if (sys_rstn) begin
      while (q.size() > 0 && q[0].tag + 2 < cyc) begin
        e = q.pop_front();
        check("missed_output", 32'(e.tag), 32'(cyc - 2));
      end
      if (q.size() > 0 && q[0].tag + 2 == cyc) begin
        e = q.pop_front();
        check("pix_data_valid", 32'(bus.pix_data_valid), 32'(e.v));
        check("pix_data", 32'(bus.pix_data), 32'(e.d));
      end
    end
  end

  // Reference model state (pixel-stream view of the screen).
  int m_prev_v;
  int m_prevh [3];
  int m_pil;
  int m_gy;
  int d_prevh [3];
  bit d_prevg;
  int hs [3][256];

  task automatic model_reset();
    m_prev_v = 0;
    m_pil    = 0;
    m_gy     = 0;
  endtask

  task automatic drive(input bit v, input int x, input int y,
                       input int h0, input int h1, input int h2, input bit g);
    int          h [3];
    logic [15:0] d;
    bit          hit [3];
    exp_t        e;
    h = '{h0, h1, h2};
    @(posedge vga_clk);
    #1;
    bus.pix_valid           = v;
    bus.pix_x               = 11'(x);
    bus.pix_y               = 11'(y);
    bus.waveform_y_sine     = 11'(d_prevh[0]);
    bus.waveform_y_triangle = 11'(d_prevh[1]);
    bus.waveform_y_square   = 11'(d_prevh[2]);
    bus.grid_en             = d_prevg;
    d_prevh = h;
    d_prevg = g;
    d = 16'h0000;
    if (!v) begin
      if (m_prev_v != 0) m_gy++;
      m_prev_v = 0;
    end else begin
      if (m_prev_v == 0) begin
        m_pil   = 0;
        if (y == 0) m_gy = 0;
        m_prevh = h;
      end
      for (int t = 0; t < 3; t++) begin
        int lo, hi;
        lo = ((m_prevh[t] < h[t]) ? m_prevh[t] : h[t]) - THICK;
        hi = ((m_prevh[t] > h[t]) ? m_prevh[t] : h[t]) + THICK;
        if (lo < 0) lo = 0;
        if (hi > 2047) hi = 2047;
        hit[t] = (y >= lo) && (y <= hi);
      end
      if (hit[0])      d = COLOR_SINE_DEF;
      else if (hit[1]) d = COLOR_TRI_DEF;
      else if (hit[2]) d = COLOR_SQR_DEF;
      else if (g && ((m_pil % GRID_X) == 0 || (m_gy % GRID_Y) == 0)) d = COLOR_GRID_DEF;
      else             d = COLOR_BG_DEF;
      m_pil++;
      m_prevh  = h;
      m_prev_v = 1;
    end
    e.tag = cyc;
    e.v   = v;
    e.d   = d;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  // gmode: 0/1 fixed grid_en, 2 random per pixel.
  task automatic line(input int y, input int n, input int gmode, input int gap);
    for (int x = 0; x < n; x++) begin
      bit g;
      g = (gmode == 2) ? 1'($urandom_range(0, 1)) : 1'(gmode);
      drive(1'b1, x, y, hs[0][x], hs[1][x], hs[2][x], g);
    end
    idle(gap);
  endtask

  task automatic set_all(input int s, input int t, input int r);
    for (int x = 0; x < 256; x++) begin
      hs[0][x] = s;
      hs[1][x] = t;
      hs[2][x] = r;
    end
  endtask

  task automatic mid_reset();
    @(posedge vga_clk);
    #2;
    sys_rstn      = 1'b0;
    bus.pix_valid = 1'b0;
    #1;
    check("async_rst_data", 32'(bus.pix_data), 32'h0);
    check("async_rst_valid", 32'(bus.pix_data_valid), 32'h0);
    q.delete();
    model_reset();
    @(posedge vga_clk);
    #1;
    sys_rstn = 1'b1;
  endtask

  initial begin
    bus.pix_valid           = 1'b0;
    bus.pix_x               = '0;
    bus.pix_y               = '0;
    bus.waveform_y_sine     = '0;
    bus.waveform_y_triangle = '0;
    bus.waveform_y_square   = '0;
    bus.grid_en             = 1'b0;
    d_prevh = '{0, 0, 0};
    d_prevg = 1'b0;
    model_reset();

    repeat (3) @(posedge vga_clk);
    #1;
    check("reset_data", 32'(bus.pix_data), 32'h0);
    check("reset_valid", 32'(bus.pix_data_valid), 32'h0);
    @(posedge vga_clk);
    #1;
    sys_rstn = 1'b1;

    idle(10);

    // Constant traces: sine on line 100, nothing on 103.
    set_all(100, 600, 600);
    line(100, 10, 0, 3);
    line(103, 10, 0, 3);

    // Square step joined by a vertical segment at x = 5.
    set_all(1500, 1500, 400);
    for (int x = 5; x < 256; x++) hs[2][x] = 450;
    for (int y = 398; y <= 452; y++) line(y, 10, 0, 2);

    // Sine over triangle priority.
    set_all(200, 200, 1500);
    line(200, 10, 0, 2);

    // Grid only, traces off-screen.
    set_all(2000, 2000, 2000);
    for (int y = 0; y <= 120; y++) line(y, 200, 1, 2);

    // Sine at the top edge with no underflow.
    set_all(0, 1500, 1500);
    for (int y = 0; y < 3; y++) line(y, 10, 0, 2);

    // No segment from one line's end into the next line's start.
    set_all(500, 1500, 1500);
    hs[0][0] = 20;
    for (int y = 15; y <= 25; y++) line(y, 10, 0, 1);
    line(250, 10, 0, 1);
    for (int y = 495; y <= 505; y++) line(y, 10, 0, 1);

    // Randomised lines, grid_en and short valid bursts, with one mid-line reset.
    for (int l = 0; l < 80; l++) begin
      int y, n;
      for (int x = 0; x < 256; x++)
        for (int t = 0; t < 3; t++) hs[t][x] = int'($urandom_range(0, 120));
      y = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 130));
      n = int'($urandom_range(1, 40));
      if (l == 40) begin
        line(y, 12, 2, 0);
        mid_reset();
      end
      line(y, n, 2, int'($urandom_range(1, 3)));
    end

    idle(4);
    repeat (4) @(posedge vga_clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
